// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Frame layout sizes and the loader state encoding.
package imem_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    function automatic logic [7:0] csum_next(
        input logic [7:0] c,
        input logic [7:0] b
    );
        return c ^ b;
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Big-endian byte-to-word assembler.
// word_done fires on the edge-cycle the last byte of a word is accepted.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_done
);

    localparam int CW = $clog2(BYTES_PER_WORD);

    logic [CW-1:0] cnt;
    logic [23:0]   sr;

    assign word      = {sr, din};
    assign word_done = en && (cnt == CW'(BYTES_PER_WORD - 1));

    // Byte counter and shift register; counter wraps per word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sr  <= '0;
        end else if (clr) begin
            cnt <= '0;
            sr  <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
            sr  <= {sr[15:0], din};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: framed byte stream to word writes.
// Holds the core in reset until a load finishes with a good checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    state_t          state;
    state_t          nstate;
    logic [15:0]     n_words;
    logic [15:0]     hdr_n;
    logic [ADDR_W:0] widx;
    logic [ADDR_W:0] widx_nxt;
    logic [7:0]      csum;
    logic            acc;
    logic            start_go;
    logic            last_word;
    logic            data_en;
    logic [31:0]     word;
    logic            word_done;

    assign acc       = in_valid && in_ready;
    assign hdr_n     = {n_words[15:8], in_data};
    assign widx_nxt  = widx + 1'b1;
    assign last_word = (16'(widx_nxt) == n_words);
    assign data_en   = acc && (state == S_DATA);
    assign start_go  = start && (state == S_IDLE ||
                                 state == S_DONE ||
                                 state == S_ERROR);

    imem_word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_go),
        .en        (data_en),
        .din       (in_data),
        .word      (word),
        .word_done (word_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nstate;
    end

    // Next-state and status decode.
    always_comb begin
        nstate   = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (start) nstate = S_HDR_HI;
            end
            S_HDR_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (acc) nstate = S_HDR_LO;
            end
            S_HDR_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (acc) begin
                    if (hdr_n > 16'(DEPTH))  nstate = S_ERROR;
                    else if (hdr_n == 16'd0) nstate = S_CSUM;
                    else                     nstate = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (word_done && last_word) nstate = S_CSUM;
            end
            S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (acc) begin
                    if (in_data == csum) nstate = S_DONE;
                    else                 nstate = S_ERROR;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) nstate = S_HDR_HI;
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) nstate = S_HDR_HI;
            end
            default: nstate = S_IDLE;
        endcase
    end

    // Header, word index, checksum and write-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_words   <= '0;
            widx      <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start_go) begin
                n_words <= '0;
                widx    <= '0;
                csum    <= '0;
            end else begin
                if (acc) begin
                    unique case (state)
                        S_HDR_HI: begin
                            n_words[15:8] <= in_data;
                            csum <= csum_next(csum, in_data);
                        end
                        S_HDR_LO: begin
                            n_words[7:0] <= in_data;
                            csum <= csum_next(csum, in_data);
                        end
                        S_DATA: begin
                            csum <= csum_next(csum, in_data);
                        end
                        default: ;
                    endcase
                end
                if (word_done) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= widx[ADDR_W-1:0];
                    mem_wdata <= word;
                    widx      <= widx_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader.
// Expected writes are queued up front and popped as mem_we pulses appear.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    int total = 0;
    int bad = 0;
    logic prev_we = 1'b0;
    logic [41:0] exp_q[$];

    logic [7:0] norm_s [0:10] = '{8'h00, 8'h02, 8'h8C, 8'h0A,
        8'h00, 8'h20, 8'h8C, 8'h0B, 8'h00, 8'h21, 8'h02};
    logic [7:0] empty_s [0:2] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] badc_s [0:6] = '{8'h00, 8'h01, 8'h00, 8'h00,
        8'h00, 8'h00, 8'hFF};

    imem_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge and score any write seen there.
    task automatic tick();
        logic [41:0] e;
        @(negedge clk);
        if (mem_we) begin
            total++;
            if (prev_we) begin
                bad++;
                $display("FAIL we_width: mem_we high two cycles in a row");
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%h data=%h",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e)
                begin
                    bad++;
                    $display("FAIL write: got %h/%h want %h/%h",
                             mem_addr, mem_wdata, e[41:32], e[31:0]);
                end
            end
        end
        prev_we = mem_we;
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain_check(input string nm);
        tick();
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_writes: left=%0d want 0",
                     nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, error,
             cpu_hold} !== {1'b0, 1'b0, 10'd0, 32'd0, 4'b0001}) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%b we=%b a=%h d=%h b=%b dn=%b e=%b h=%b",
                     in_ready, mem_we, mem_addr, mem_wdata, busy, done,
                     error, cpu_hold);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({in_ready, busy, cpu_hold} !== 3'b001) begin
            bad++;
            $display("FAIL idle_after_reset: rdy/busy/hold=%b want 001",
                     {in_ready, busy, cpu_hold});
        end
    endtask

    task automatic test_normal(input string nm);
        exp_q.push_back({10'd0, 32'h8C0A0020});
        exp_q.push_back({10'd1, 32'h8C0B0021});
        pulse_start();
        total++;
        if ({busy, in_ready, cpu_hold, done} !== 4'b1110) begin
            bad++;
            $display("FAIL %s_started: busy/rdy/hold/done=%b want 1110",
                     nm, {busy, in_ready, cpu_hold, done});
        end
        for (int i = 0; i < 11; i++) send(norm_s[i]);
        total++;
        if ({done, error, cpu_hold, in_ready, busy} !== 5'b10000) begin
            bad++;
            $display("FAIL %s_done: done/err/hold/rdy/busy=%b want 10000",
                     nm, {done, error, cpu_hold, in_ready, busy});
        end
        drain_check(nm);
        total++;
        if (mem_wdata !== 32'h8C0B0021 || mem_addr !== 10'd1) begin
            bad++;
            $display("FAIL %s_hold_wdata: got %h/%h want 001/8c0b0021",
                     nm, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_empty();
        pulse_start();
        for (int i = 0; i < 3; i++) send(empty_s[i]);
        total++;
        if ({done, error, cpu_hold, in_ready} !== 4'b1000) begin
            bad++;
            $display("FAIL empty_done: done/err/hold/rdy=%b want 1000",
                     {done, error, cpu_hold, in_ready});
        end
        drain_check("empty");
    endtask

    task automatic test_bad_csum();
        exp_q.push_back({10'd0, 32'h00000000});
        pulse_start();
        total++;
        if ({done, error} !== 2'b00) begin
            bad++;
            $display("FAIL restart_clears: done/err=%b want 00",
                     {done, error});
        end
        for (int i = 0; i < 7; i++) send(badc_s[i]);
        total++;
        if ({error, cpu_hold, done, busy, in_ready} !== 5'b11000) begin
            bad++;
            $display("FAIL badcsum_err: err/hold/done/busy/rdy=%b want 11000",
                     {error, cpu_hold, done, busy, in_ready});
        end
        drain_check("badcsum");
    endtask

    task automatic test_oversize();
        pulse_start();
        send(8'h04);
        send(8'h01);
        total++;
        if ({error, in_ready, busy, cpu_hold} !== 4'b1001) begin
            bad++;
            $display("FAIL oversize_err: err/rdy/busy/hold=%b want 1001",
                     {error, in_ready, busy, cpu_hold});
        end
        drain_check("oversize");
    endtask

    task automatic test_backpressure();
        exp_q.push_back({10'd0, 32'h8C0A0020});
        exp_q.push_back({10'd1, 32'h8C0B0021});
        pulse_start();
        for (int i = 0; i < 11; i++) begin
            send(norm_s[i]);
            if (i < 10) begin
                if (i == 5) start = 1'b1;
                tick();
                start = 1'b0;
                tick();
                tick();
            end
        end
        total++;
        if ({done, error, cpu_hold, in_ready} !== 4'b1000) begin
            bad++;
            $display("FAIL bp_done: done/err/hold/rdy=%b want 1000",
                     {done, error, cpu_hold, in_ready});
        end
        drain_check("bp");
    endtask

    task automatic test_reset_midload();
        pulse_start();
        for (int i = 0; i < 5; i++) send(norm_s[i]);
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, error,
             cpu_hold} !== {1'b0, 1'b0, 10'd0, 32'd0, 4'b0001}) begin
            bad++;
            $display("FAIL midload_reset: rdy=%b we=%b a=%h d=%h b=%b dn=%b e=%b h=%b",
                     in_ready, mem_we, mem_addr, mem_wdata, busy, done,
                     error, cpu_hold);
        end
        tick();
        tick();
        rst = 1'b0;
        drain_check("midload");
        test_normal("reload");
    endtask

    initial begin
        test_reset();
        test_normal("normal");
        test_empty();
        test_bad_csum();
        test_oversize();
        test_backpressure();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader that fills the 1024-word instruction memory before the core runs. It is the writer counterpart to the instruction-memory read port.
- Accepts a framed byte stream from a host/UART bridge over a valid/ready handshake and assembles big-endian 32-bit words.
- Issues single-cycle writes at incrementing word addresses and verifies an XOR checksum.
- Holds the CPU in reset until a load completes cleanly.

Parameters:
- ADDR_W, 10, word-address width of instruction memory.
- DEPTH, 1024, number of words in instruction memory; maximum legal word count.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a load; ignored while busy.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader can accept a byte; transfer occurs when in_valid && in_ready on a rising edge.
- mem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  write data.
- busy  out  1  load in progress.
- done  out  1  last load succeeded; sticky until next start or rst.
- error  out  1  last load failed; sticky until next start or rst.
- cpu_hold  out  1  keeps the core in reset; low only while done=1.

Behaviour:
- Reset (rst=1, async):
  - State IDLE; all counters and the checksum are 0.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=1.
  - A reset mid-load aborts the load: no further writes and no partial-word write.
- Frame format:
  - 2 header bytes giving word count N, 16-bit big-endian.
  - Then 4*N data bytes, 4 per word, first byte to mem_wdata[31:24].
  - Then 1 checksum byte.
- Checksum rule: the checksum byte must equal the XOR of all header and data bytes.
- States: IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERROR.
- Start:
  - start=1 in IDLE, DONE or ERROR moves to HDR_HI on the next edge.
  - On the same edge: clear done, error, word and byte counters, and checksum; set busy=1 and cpu_hold=1.
  - start is ignored in HDR_HI, HDR_LO, DATA and CSUM.
- in_ready is 1 exactly in HDR_HI, HDR_LO, DATA and CSUM. A stalled in_valid holds the state indefinitely, with no timeout.
- HDR_HI: an accepted byte becomes N[15:8]; go to HDR_LO.
- HDR_LO: an accepted byte becomes N[7:0]. Then:
  - N > DEPTH: go to ERROR.
  - N = 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA:
  - A 2-bit byte counter shifts bytes into a 32-bit assembly register.
  - On acceptance of the 4th byte of a word:
    - On the next cycle mem_we=1 for exactly one cycle, with mem_addr = word index (0..N-1) and mem_wdata = the assembled word.
    - mem_addr and mem_wdata hold their values until the next write.
    - The word index increments.
  - After word N-1's 4th byte is accepted, go to CSUM.
  - Latency: 1 cycle from the 4th-byte edge to the mem_we cycle.
  - Back-to-back bytes at full rate are supported; a write overlaps acceptance of the next word's bytes.
- CSUM: an accepted byte is compared with the running XOR.
  - Match: go to DONE.
  - Mismatch: go to ERROR.
- DONE: busy=0, done=1, cpu_hold=0.
- ERROR: busy=0, error=1, cpu_hold=1.
- Memory contents after an error: words already written stay written; the memory is not cleared.
- Arithmetic:
  - Word index is ADDR_W+1 bits wide so that N=DEPTH is representable.
  - The header compare is done at 16 bits.
  - The checksum is an 8-bit XOR with no carry.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum;
  - HDR_BYTES=2;
  - BYTES_PER_WORD=4.
- Sub-module imem_word_assembler holds:
  - the byte counter and shift register;
  - a word_done pulse output.
- The top-level FSM owns the header, word index, checksum and memory-write registers.

Test Plan:
- Normal load:
  - start, then bytes 00 02 8C 0A 00 20 8C 0B 00 21 02.
  - Required: writes addr0=8C0A0020 and addr1=8C0B0021, each mem_we exactly one cycle.
  - Then done=1, cpu_hold=0, error=0, in_ready=0.
- Empty program: start, then bytes 00 00 00 -> no mem_we, done=1.
- Bad checksum:
  - start, then bytes 00 01 00 00 00 00 FF (checksum 01 expected).
  - Required: one write addr0=00000000, then error=1, cpu_hold=1.
- Oversize header: start, then bytes 04 01 (N=1025) -> error=1 and in_ready=0 immediately after the 2nd byte; no writes.
- Backpressure and ignored start:
  - Repeat the normal-load stream with in_valid low for 3 cycles between each byte.
  - Pulse start mid-stream.
  - Required: same two writes with the same data, start has no effect, done=1.
- Reset mid-load and restart:
  - Assert rst after the 3rd data byte.
  - Required: all outputs at reset values and no write.
  - A subsequent normal load succeeds with addr0 written first.
